// File: rtl/fb_write_scheduler_if.sv
// Pixel-in / framebuffer-write-port bundle for fb_write_scheduler.
// master: engine + driver side; slave: the scheduler.
interface fb_write_scheduler_if;
   logic        pix_valid_in;
   logic [3:0]  pix_data_in;
   logic        pix_ready_out;
   logic        frame_start_in;
   logic        fb_read_in;
   logic [3:0]  fb_write_data_out;
   logic        fb_write_out;
   logic        fb_reset_write_ptr_out;
   logic        fb_wrote_data_in;
   logic        busy_out;
   logic        frame_done_out;
   logic [16:0] pixel_count_out;
   logic        err_out;

   modport master (
      output pix_valid_in, pix_data_in, frame_start_in, fb_read_in, fb_wrote_data_in,
      input  pix_ready_out, fb_write_data_out, fb_write_out, fb_reset_write_ptr_out,
      input  busy_out, frame_done_out, pixel_count_out, err_out
   );

   modport slave (
      input  pix_valid_in, pix_data_in, frame_start_in, fb_read_in, fb_wrote_data_in,
      output pix_ready_out, fb_write_data_out, fb_write_out, fb_reset_write_ptr_out,
      output busy_out, frame_done_out, pixel_count_out, err_out
   );
endinterface

// File: rtl/fb_write_scheduler.sv
// Buffers engine pixels and sequences them into the framebuffer write port.
// Optional echo check enabled by defining FB_ACK_CHECK_EN.
module fb_write_scheduler #(
   parameter int unsigned FIFO_DEPTH    = 4,
   parameter int unsigned FRAME_PIXELS  = 76800,
   parameter int unsigned STROBE_CYCLES = 2,
   parameter int unsigned GAP_CYCLES    = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   fb_write_scheduler_if.slave  bus
);

   localparam int unsigned AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CMAX = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
   localparam int unsigned CW   = $clog2(CMAX + 1);

   localparam logic [AW:0]   FifoFull   = (AW + 1)'(FIFO_DEPTH);
   localparam logic [16:0]   LastCount  = 17'(FRAME_PIXELS - 1);
   localparam logic [CW-1:0] StrobeLast = CW'(STROBE_CYCLES - 1);
   localparam logic [CW-1:0] GapLast    = CW'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      StIdle,
      StPtrRst,
      StSetup,
      StStrobe,
      StAck,
      StGap
   } state_e;

   // FIFO storage and pointers
   logic [3:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   fifo_cnt_q;
   logic          fifo_ne_q;
   logic          push, pop, pix_ready, head_avail;

   // FSM and datapath state
   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    data_q, data_d;
   logic          pend_rst_q, pend_rst_d;
   logic          uncounted_q, uncounted_d;
   logic [16:0]   pix_cnt_q, pix_cnt_d;
   logic          frame_done_q, frame_done_d;
   logic          ack_seen_q, ack_seen_d;
   logic          ack_first_q, ack_first_d;
   logic          count_event;

   assign pix_ready = (fifo_cnt_q != FifoFull);
   assign push      = bus.pix_valid_in && pix_ready && !bus.frame_start_in;
   // Non-empty as seen by the FSM trails the push by a cycle; the live count
   // masks a stale flag after a pop or flush.
   assign head_avail = fifo_ne_q && (fifo_cnt_q != '0);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= bus.pix_data_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
         fifo_ne_q  <= 1'b0;
      end else if (bus.frame_start_in) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
         fifo_ne_q  <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
            default: fifo_cnt_q <= fifo_cnt_q;
         endcase
         fifo_ne_q <= (fifo_cnt_q != '0);
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      data_d       = data_q;
      pend_rst_d   = pend_rst_q;
      uncounted_d  = uncounted_q;
      pix_cnt_d    = pix_cnt_q;
      frame_done_d = 1'b0;
      ack_seen_d   = ack_seen_q;
      ack_first_d  = ack_first_q;
      pop          = 1'b0;
      count_event  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (pend_rst_q) begin
               state_d    = StPtrRst;
               cnt_d      = '0;
               pend_rst_d = 1'b0;
            end else if (head_avail && !bus.fb_read_in && !bus.frame_start_in) begin
               state_d     = StSetup;
               pop         = 1'b1;
               data_d      = mem[rd_ptr_q];
               uncounted_d = 1'b0;
            end
         end
         StPtrRst: begin
            if (cnt_q == StrobeLast) begin
               state_d = StGap;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StSetup: begin
            state_d    = StStrobe;
            cnt_d      = '0;
            ack_seen_d = 1'b0;
         end
         StStrobe: begin
            if (bus.fb_wrote_data_in) ack_seen_d = 1'b1;
            if (cnt_q == StrobeLast) begin
               state_d     = StAck;
               ack_first_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StAck: begin
            ack_first_d = 1'b0;
            if (bus.fb_wrote_data_in && ack_first_q) ack_seen_d = 1'b1;
            // Echo trails the strobe by a cycle; leave once it has dropped.
            if (!bus.fb_wrote_data_in) begin
               state_d     = StGap;
               cnt_d       = '0;
               count_event = 1'b1;
            end
         end
         StGap: begin
            if (cnt_q == GapLast) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (count_event && !uncounted_q) begin
         if (pix_cnt_q == LastCount) begin
            pix_cnt_d    = '0;
            frame_done_d = 1'b1;
            pend_rst_d   = 1'b1;
         end else begin
            pix_cnt_d = pix_cnt_q + 17'd1;
         end
      end

      // Frame restart wins over both a completing write and an end-of-frame.
      if (bus.frame_start_in) begin
         pix_cnt_d    = '0;
         frame_done_d = 1'b0;
         pend_rst_d   = 1'b1;
         uncounted_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         data_q       <= '0;
         pend_rst_q   <= 1'b1;
         uncounted_q  <= 1'b0;
         pix_cnt_q    <= '0;
         frame_done_q <= 1'b0;
         ack_seen_q   <= 1'b0;
         ack_first_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         data_q       <= data_d;
         pend_rst_q   <= pend_rst_d;
         uncounted_q  <= uncounted_d;
         pix_cnt_q    <= pix_cnt_d;
         frame_done_q <= frame_done_d;
         ack_seen_q   <= ack_seen_d;
         ack_first_q  <= ack_first_d;
      end
   end

`ifdef FB_ACK_CHECK_EN
   logic err_q;

   // Echo must have been seen during STROBE or the first ACK cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (count_event && !ack_seen_q) begin
         err_q <= 1'b1;
      end
   end

   assign bus.err_out = err_q;
`else
   assign bus.err_out = 1'b0;
`endif

   assign bus.pix_ready_out          = pix_ready;
   assign bus.fb_write_data_out      = data_q;
   assign bus.fb_write_out           = (state_q == StStrobe);
   assign bus.fb_reset_write_ptr_out = (state_q == StPtrRst);
   assign bus.busy_out               = (state_q != StIdle);
   assign bus.frame_done_out         = frame_done_q;
   assign bus.pixel_count_out        = pix_cnt_q;

endmodule

// File: doc/fb_write_scheduler.md
Name: fb_write_scheduler

Overview:
- Sequences pixel writes from the Mandelbrot iteration engine into the QSPI framebuffer write port of the VGA framebuffer driver.
- Buffers results in a small FIFO and issues write strobes and write-pointer resets.
- Checks the registered write echo, and counts pixels per frame.
- Sits between the engine's pixel output and the driver's write_data_in / write_data / reset_write_ptr / wrote_data signals.

Parameters:
FIFO_DEPTH, 4, pixel FIFO entries; power of two, at least 2
FRAME_PIXELS, 76800, writes per frame before the pointer rewinds
STROBE_CYCLES, 2, cycles fb_write_out (or fb_reset_write_ptr_out) is held high; at least 1
GAP_CYCLES, 2, idle cycles after each transaction; at least 1

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
pix_valid_in  in  1  engine offers a pixel
pix_data_in  in  4  gray value of the offered pixel
pix_ready_out  out  1  FIFO not full; a push happens when valid and ready are both high
frame_start_in  in  1  one-cycle pulse: restart the frame
fb_read_in  in  1  driver read slot active (driver's read term)
fb_write_data_out  out  4  pixel value to the framebuffer
fb_write_out  out  1  write strobe
fb_reset_write_ptr_out  out  1  write-pointer reset strobe
fb_wrote_data_in  in  1  registered write echo from the driver
busy_out  out  1  FSM not in IDLE
frame_done_out  out  1  one-cycle pulse after the FRAME_PIXELS-th write
pixel_count_out  out  17  completed writes in the current frame
err_out  out  1  sticky echo error (see Optional Feature)

Behaviour:
- Reset state:
  - One clock; reset is asynchronous and active-low.
  - During reset: FIFO empty, pix_ready_out=1, all strobes 0, fb_write_data_out=0, busy_out=0, frame_done_out=0, pixel_count_out=0, err_out=0.
  - FSM in IDLE with pend_rst=1, so the first transaction after reset is a pointer reset.
- FIFO:
  - Registered FIFO, first in first out; pix_ready_out = !full.
  - A push and a pop in the same cycle are both honoured.
  - A push while full cannot occur, because ready is low.
- FSM states: IDLE, PTR_RST, SETUP, STROBE, ACK, GAP. All outputs decode from registered state.
- IDLE:
  - If pend_rst=1 -> PTR_RST.
  - Else if the FIFO is non-empty and fb_read_in=0 -> SETUP, popping the head into the data register.
  - Else stay in IDLE.
  - A transaction never starts while fb_read_in=1.
  - A started transaction is not interrupted by fb_read_in.
- PTR_RST:
  - fb_reset_write_ptr_out=1 for STROBE_CYCLES cycles, then -> GAP.
  - Clears pend_rst; no pixel is counted.
- SETUP: one cycle; fb_write_data_out holds the popped value, fb_write_out=0; -> STROBE.
- STROBE: fb_write_out=1 for STROBE_CYCLES cycles with data held stable; -> ACK.
- ACK:
  - fb_write_out=0; wait until fb_wrote_data_in=0 (the echo trails the strobe by one cycle), then -> GAP.
  - On exit, pixel_count_out increments.
- GAP: GAP_CYCLES cycles, all strobes low, data held; -> IDLE.
- Latency: a pixel pushed at edge N, with the FIFO empty, FSM in IDLE, pend_rst=0 and fb_read_in=0, gives:
  - fb_write_data_out valid from edge N+2;
  - fb_write_out high from edge N+3 for STROBE_CYCLES cycles.
- End of frame:
  - When the increment reaches FRAME_PIXELS, pixel_count_out wraps to 0 instead.
  - frame_done_out pulses for one cycle and pend_rst is set.
- frame_start_in:
  - Flushes the FIFO and clears pixel_count_out to 0; sets pend_rst.
  - An in-flight transaction completes but is not counted.
  - Takes priority over a simultaneous push; that pixel is dropped, and upstream must not push in that cycle.
  - Takes priority over a simultaneous end-of-frame event; frame_done_out is suppressed.
- Asynchronous reset mid-transaction aborts immediately to the reset state.

Optional Feature:
FB_ACK_CHECK_EN:
- Defined:
  - The FSM records whether fb_wrote_data_in was seen high during STROBE or the first ACK cycle.
  - If it was not, err_out is set sticky until reset; the pixel is still counted and the sequence continues.
- Undefined:
  - No check; err_out is tied to 0.

Test Plan:
- Reset release, then idle 20 cycles -> fb_reset_write_ptr_out high exactly 2 cycles, then busy_out=0; pixel_count_out=0.
- Push 0xA, with echo modelled as the 1-cycle delayed strobe -> data 0xA from edge N+2; fb_write_out high at N+3..N+4; pixel_count_out=1 after GAP.
- Push 6 pixels back-to-back with FIFO_DEPTH=4 -> pix_ready_out falls after the 4th (or 5th, counting the simultaneous pop); order preserved; all 6 written; count=6.
- Hold fb_read_in=1 with the FIFO non-empty -> no SETUP entered; on release, SETUP next cycle.
- FRAME_PIXELS=8, write 8 pixels -> frame_done_out single pulse; count=0; next transaction is PTR_RST before the 9th pixel.
- frame_start_in during STROBE with 3 queued -> current write finishes uncounted; FIFO empty; PTR_RST follows; count=0. With FB_ACK_CHECK_EN and the echo held low -> err_out=1 and stays 1.
